// File: rtl/maze_pkg.sv
//------------------------------------------------------------------------------
// Module  : maze_pkg
// Brief   : Shared move encodings, error codes and FSM states for the maze
//           path checker.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package maze_pkg;

    localparam int MAZE_N_DEFAULT = 17;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_WALL    = 3'd1;
    localparam logic [2:0] ERR_SHORT   = 3'd2;
    localparam logic [2:0] ERR_EXTRA   = 3'd3;
    localparam logic [2:0] ERR_PROTO   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WALK  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/maze_step.sv
//------------------------------------------------------------------------------
// Module  : maze_step
// Brief   : Combinational single-move evaluator: next cell, bounds check and
//           wall lookup against the captured maze.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module maze_step
    import maze_pkg::*;
#(
    parameter int N     = MAZE_N_DEFAULT,
    parameter int POS_W = $clog2(N)
) (
    input  logic [POS_W-1:0] i_row,
    input  logic [POS_W-1:0] i_col,
    input  logic [1:0]       i_move,
    input  logic [N*N-1:0]   i_maze,
    output logic [POS_W-1:0] o_next_row,
    output logic [POS_W-1:0] o_next_col,
    output logic             o_illegal
);

    localparam int c_idx_w = $clog2(N*N);

    logic               w_oob;
    logic [POS_W-1:0]   w_row;
    logic [POS_W-1:0]   w_col;
    logic [c_idx_w-1:0] w_idx;

    // Edge tests happen before the add/subtract so a wrapped coordinate can
    // never look like a legal in-range cell.
    always_comb begin
        w_oob = 1'b0;
        w_row = i_row;
        w_col = i_col;
        case (i_move)
            DIR_RIGHT: begin
                if (i_col == POS_W'(N-1)) w_oob = 1'b1;
                else                      w_col = i_col + POS_W'(1);
            end
            DIR_DOWN: begin
                if (i_row == POS_W'(N-1)) w_oob = 1'b1;
                else                      w_row = i_row + POS_W'(1);
            end
            DIR_LEFT: begin
                if (i_col == '0) w_oob = 1'b1;
                else             w_col = i_col - POS_W'(1);
            end
            default: begin
                if (i_row == '0) w_oob = 1'b1;
                else             w_row = i_row - POS_W'(1);
            end
        endcase
    end

    assign w_idx      = c_idx_w'(w_row) * c_idx_w'(N) + c_idx_w'(w_col);
    assign o_next_row = w_row;
    assign o_next_col = w_col;
    assign o_illegal  = w_oob | i_maze[w_idx];

endmodule

`default_nettype wire

// File: rtl/maze_path_checker.sv
//------------------------------------------------------------------------------
// Module  : maze_path_checker
// Brief   : Captures the serial maze bitstream, walks the solver's move stream
//           and reports pass/fail, error code and legal step count.
//           Optional build macro MAZE_CHK_TIMEOUT_EN adds a WAIT timeout.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module maze_path_checker
    import maze_pkg::*;
#(
    parameter int N        = MAZE_N_DEFAULT,
    parameter int MAX_WAIT = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in,
    input  logic                       out_valid,
    input  logic [1:0]                 out,
    output logic                       chk_done,
    output logic                       chk_pass,
    output logic [2:0]                 chk_err,
    output logic [$clog2(N*N+1)-1:0]   step_cnt
);

    localparam int c_cells  = N * N;
    localparam int c_pos_w  = $clog2(N);
    localparam int c_idx_w  = $clog2(N*N);
    localparam int c_step_w = $clog2(N*N+1);

    state_t                r_state;
    state_t                w_state;
    logic [c_cells-1:0]    r_maze;
    logic [c_idx_w-1:0]    r_bit_cnt;
    logic [c_idx_w-1:0]    w_bit_cnt;
    logic [c_pos_w-1:0]    r_row;
    logic [c_pos_w-1:0]    r_col;
    logic [c_pos_w-1:0]    w_row;
    logic [c_pos_w-1:0]    w_col;
    logic                  r_done;
    logic                  r_pass;
    logic [2:0]            r_err;
    logic [c_step_w-1:0]   r_step;
    logic                  w_done;
    logic                  w_pass;
    logic [2:0]            w_err;
    logic [c_step_w-1:0]   w_step;

    logic                  w_wr_en;
    logic [c_idx_w-1:0]    w_wr_idx;
    logic                  w_walk;
    logic                  w_fail;
    logic [2:0]            w_fail_code;
    logic                  w_timeout;

    logic [c_pos_w-1:0]    w_next_row;
    logic [c_pos_w-1:0]    w_next_col;
    logic                  w_illegal;
    logic                  w_at_goal;

    maze_step #(
        .N     (N),
        .POS_W (c_pos_w)
    ) u_step (
        .i_row      (r_row),
        .i_col      (r_col),
        .i_move     (out),
        .i_maze     (r_maze),
        .o_next_row (w_next_row),
        .o_next_col (w_next_col),
        .o_illegal  (w_illegal)
    );

    assign w_at_goal = (w_next_row == c_pos_w'(N-1)) && (w_next_col == c_pos_w'(N-1));

`ifdef MAZE_CHK_TIMEOUT_EN
    localparam int c_wait_w = $clog2(MAX_WAIT + 1);

    logic [c_wait_w-1:0] r_wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT && w_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == c_wait_w'(MAX_WAIT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state     = r_state;
        w_bit_cnt   = r_bit_cnt;
        w_row       = r_row;
        w_col       = r_col;
        w_done      = r_done;
        w_pass      = r_pass;
        w_err       = r_err;
        w_step      = r_step;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_bit_cnt;
        w_walk      = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = ERR_NONE;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (in_valid) begin
                    w_state   = ST_LOAD;
                    w_wr_en   = 1'b1;
                    w_wr_idx  = '0;
                    w_bit_cnt = c_idx_w'(1);
                    w_row     = '0;
                    w_col     = '0;
                    w_done    = 1'b0;
                    w_pass    = 1'b0;
                    w_err     = ERR_NONE;
                    w_step    = '0;
                end
            end
            ST_LOAD: begin
                if (out_valid || !in_valid) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_PROTO;
                end else begin
                    w_wr_en = 1'b1;
                    if (r_bit_cnt == c_idx_w'(c_cells-1)) w_state = ST_WAIT;
                    else                                   w_bit_cnt = r_bit_cnt + c_idx_w'(1);
                end
            end
            ST_WAIT: begin
                if (in_valid) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_PROTO;
                end else if (out_valid) begin
                    w_walk = 1'b1;
                end else if (w_timeout) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TIMEOUT;
                end
            end
            ST_WALK: begin
                if (in_valid) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_PROTO;
                end else if (!out_valid) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_SHORT;
                end else begin
                    w_walk = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (in_valid) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_PROTO;
                end else if (out_valid) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_EXTRA;
                end else begin
                    w_state = ST_DONE;
                    w_done  = 1'b1;
                    w_pass  = 1'b1;
                    w_err   = ERR_NONE;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // A move beat either fails in place or advances the walker by one cell.
        if (w_walk) begin
            if (w_illegal) begin
                w_fail      = 1'b1;
                w_fail_code = ERR_WALL;
            end else begin
                w_row   = w_next_row;
                w_col   = w_next_col;
                w_step  = r_step + c_step_w'(1);
                w_state = w_at_goal ? ST_DRAIN : ST_WALK;
            end
        end

        if (w_fail) begin
            w_state = ST_DONE;
            w_done  = 1'b1;
            w_pass  = 1'b0;
            w_err   = w_fail_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_maze    <= '0;
            r_bit_cnt <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= ERR_NONE;
            r_step    <= '0;
        end else begin
            r_state   <= w_state;
            r_bit_cnt <= w_bit_cnt;
            r_row     <= w_row;
            r_col     <= w_col;
            r_done    <= w_done;
            r_pass    <= w_pass;
            r_err     <= w_err;
            r_step    <= w_step;
            if (w_wr_en) begin
                r_maze[w_wr_idx] <= in;
            end
        end
    end

    assign chk_done = r_done;
    assign chk_pass = r_pass;
    assign chk_err  = r_err;
    assign step_cnt = r_step;

endmodule

`default_nettype wire

// File: tb/tb_maze_path_checker.sv
//------------------------------------------------------------------------------
// Module  : tb_maze_path_checker
// Brief   : Directed self-checking bench for maze_path_checker with a
//           path-walking reference model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_maze_path_checker;

    localparam int N     = 17;
    localparam int CELLS = N * N;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       out_valid;
    logic [1:0] out_mv;
    logic       chk_done;
    logic       chk_pass;
    logic [2:0] chk_err;
    logic [8:0] step_cnt;

    always #5 clk = ~clk;

    maze_path_checker #(
        .N        (N),
        .MAX_WAIT (1023)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in_bit),
        .out_valid (out_valid),
        .out       (out_mv),
        .chk_done  (chk_done),
        .chk_pass  (chk_pass),
        .chk_err   (chk_err),
        .step_cnt  (step_cnt)
    );

    bit mz [CELLS];
    int mv [$];
    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;
    int exp_done = 0;
    int exp_pass = 0;
    int exp_err  = 0;
    int exp_step = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input int err, input int step);
        exp_done = 1;
        exp_pass = (err == 0) ? 1 : 0;
        exp_err  = err;
        exp_step = step;
    endtask

    task automatic clear_exp();
        exp_done = 0;
        exp_pass = 0;
        exp_err  = 0;
        exp_step = 0;
    endtask

    // Outputs are held between decisions, so every cycle is meaningful.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("done", chk_done, exp_done);
            if (exp_done != 0) begin
                chk("pass", chk_pass, exp_pass);
                chk("err", chk_err, exp_err);
                chk("step", step_cnt, exp_step);
            end else begin
                chk("pass_low", chk_pass, 0);
                chk("err_zero", chk_err, 0);
            end
        end
    end

    // Reference: walk the move list on a grid; returns the verdict and the
    // index of the sample (move beat or the out_valid drop) that decides it.
    task automatic model_walk(output int e_err, output int e_step, output int e_dec);
        int r = 0;
        int c = 0;
        int nr;
        int nc;
        e_err  = 2;
        e_step = 0;
        e_dec  = mv.size();
        for (int i = 0; i < mv.size(); i++) begin
            nr = r;
            nc = c;
            case (mv[i])
                0: nc = c + 1;
                1: nr = r + 1;
                2: nc = c - 1;
                default: nr = r - 1;
            endcase
            if (nr < 0 || nr >= N || nc < 0 || nc >= N || mz[nr*N + nc]) begin
                e_err = 1;
                e_dec = i;
                return;
            end
            r = nr;
            c = nc;
            e_step++;
            if (r == N-1 && c == N-1) begin
                e_err = (i + 1 < mv.size()) ? 3 : 0;
                e_dec = i + 1;
                return;
            end
        end
    endtask

    task automatic open_maze();
        for (int i = 0; i < CELLS; i++) mz[i] = 1'b0;
    endtask

    task automatic add_moves(input int dir, input int count);
        repeat (count) mv.push_back(dir);
    endtask

    task automatic load_maze(input int gap_at);
        for (int i = 0; i < CELLS; i++) begin
            if (i == gap_at) begin
                in_valid = 1'b0;
                tick();
                set_exp(4, 0);
                repeat (2) tick();
                return;
            end
            in_valid = 1'b1;
            in_bit   = mz[i];
            tick();
            if (i == 0) clear_exp();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic run_walk(input int pre_idle, output int m_err, output int m_step);
        int dec;
        model_walk(m_err, m_step, dec);
        out_valid = 1'b0;
        repeat (pre_idle) tick();
        for (int j = 0; j <= mv.size(); j++) begin
            if (j < mv.size()) begin
                out_valid = 1'b1;
                out_mv    = 2'(mv[j]);
            end else begin
                out_valid = 1'b0;
            end
            tick();
            if (j == dec) set_exp(m_err, m_step);
        end
        out_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pin(input string name, input int m_err, input int m_step, input int l_err, input int l_step);
        chk({name, "_model_err"}, m_err, l_err);
        chk({name, "_model_step"}, m_step, l_step);
        chk({name, "_dut_err"}, chk_err, l_err);
        chk({name, "_dut_step"}, step_cnt, l_step);
        chk({name, "_dut_pass"}, chk_pass, (l_err == 0) ? 1 : 0);
    endtask

    initial begin
        int e;
        int s;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_valid = 1'b0;
        out_mv    = 2'd0;
        repeat (2) tick();
        chk("rst_done", chk_done, 0);
        chk("rst_pass", chk_pass, 0);
        chk("rst_err", chk_err, 0);
        chk("rst_step", step_cnt, 0);
        rst    = 1'b0;
        cmp_on = 1'b1;
        tick();

        // Open maze, long idle in WAIT, then the straight 32-move path.
        open_maze();
        mv.delete(); add_moves(0, 16); add_moves(1, 16);
        load_maze(-1);
        run_walk(40, e, s);
        pin("open_pass", e, s, 0, 32);

        // Wall directly right of start.
        open_maze(); mz[1] = 1'b1;
        mv.delete(); add_moves(0, 1); add_moves(1, 3);
        load_maze(-1);
        run_walk(0, e, s);
        pin("wall_right", e, s, 1, 0);

        // Up out of the grid from the start cell.
        open_maze();
        mv.delete(); add_moves(3, 1);
        load_maze(-1);
        run_walk(0, e, s);
        pin("oob_up", e, s, 1, 0);

        // Down past the bottom edge after reaching the last row.
        mv.delete(); add_moves(1, 17);
        load_maze(-1);
        run_walk(1, e, s);
        pin("oob_down", e, s, 1, 16);

        // Path stops early.
        mv.delete(); add_moves(0, 5); add_moves(1, 5);
        load_maze(-1);
        run_walk(0, e, s);
        pin("short", e, s, 2, 10);

        // One beat beyond the goal.
        mv.delete(); add_moves(0, 16); add_moves(1, 16); add_moves(2, 1);
        load_maze(-1);
        run_walk(0, e, s);
        pin("extra", e, s, 3, 32);

        // in_valid gap in the middle of the maze load.
        load_maze(100);
        chk("gap_dut_err", chk_err, 4);
        chk("gap_dut_step", step_cnt, 0);

        // Wall column with a winding path: revisits, left and up moves.
        open_maze();
        for (int r = 0; r < 15; r++) mz[r*N + 1] = 1'b1;
        mv.delete(); add_moves(1, 1); add_moves(3, 1); add_moves(1, 16);
        add_moves(0, 15); add_moves(2, 1); add_moves(0, 2);
        load_maze(-1);
        run_walk(2, e, s);
        pin("winding", e, s, 0, 36);

        // Same maze, turn into the wall column mid-path.
        mv.delete(); add_moves(1, 5); add_moves(0, 1);
        load_maze(-1);
        run_walk(0, e, s);
        pin("wall_mid", e, s, 1, 5);

        // New maze bit while walking takes priority over the move beat.
        open_maze();
        load_maze(-1);
        for (int j = 0; j < 3; j++) begin
            out_valid = 1'b1;
            out_mv    = 2'd0;
            tick();
        end
        in_valid = 1'b1;
        in_bit   = 1'b0;
        tick();
        set_exp(4, 3);
        in_valid  = 1'b0;
        out_valid = 1'b0;
        repeat (3) tick();
        chk("proto_walk_err", chk_err, 4);
        chk("proto_walk_step", step_cnt, 3);

        // Reset in the middle of a walk, then a clean full run.
        load_maze(-1);
        for (int j = 0; j < 5; j++) begin
            out_valid = 1'b1;
            out_mv    = 2'd1;
            tick();
        end
        out_valid = 1'b0;
        rst       = 1'b1;
        #1;
        chk("midrst_step", step_cnt, 0);
        chk("midrst_done", chk_done, 0);
        tick();
        rst = 1'b0;
        tick();
        mv.delete(); add_moves(1, 16); add_moves(0, 16);
        load_maze(-1);
        run_walk(0, e, s);
        pin("after_rst", e, s, 0, 32);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
